// File: rtl/dropout_mask_gen_pkg.sv
// Shared constants and FSM encoding for the dropout keep-mask generator and
// the other LFSR-driven stochastic blocks.
package dropout_pkg;

  localparam int                  LFSR_W       = 16;
  localparam logic [LFSR_W-1:0]   LFSR_POLY    = 16'hB400;
  localparam logic [LFSR_W-1:0]   DEFAULT_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/dropout_mask_gen_if.sv
// Valid/ready mask channel between the mask generator and the dropout stage.
interface dropout_mask_gen_if #(
  parameter int WIDTH = 8
) ();

  logic             mask_valid;
  logic             mask_ready;
  logic [WIDTH-1:0] mask;
  logic [4:0]       drop_count;

  modport master (
    output mask_valid,
    output mask,
    output drop_count,
    input  mask_ready
  );

  modport slave (
    input  mask_valid,
    input  mask,
    input  drop_count,
    output mask_ready
  );

endinterface

// File: rtl/dropout_mask_gen_lfsr16_step.sv
// Combinational next-state function of the 16-bit Galois LFSR, plus the
// zero-seed substitution that keeps the register out of the lock-up state.
module lfsr16_step
  import dropout_pkg::*;
#(
  parameter logic [LFSR_W-1:0] ZERO_SEED = DEFAULT_SEED
) (
  input  logic [LFSR_W-1:0] lfsr_cur,
  input  logic [LFSR_W-1:0] seed_raw,
  output logic [LFSR_W-1:0] lfsr_next,
  output logic [LFSR_W-1:0] seed_safe
);

  assign lfsr_next = (lfsr_cur >> 1) ^ (lfsr_cur[0] ? LFSR_POLY : '0);
  assign seed_safe = (seed_raw == '0) ? ZERO_SEED : seed_raw;

endmodule

// File: rtl/dropout_mask_gen.sv
// Keep-mask generator: one LFSR-driven lane decision per cycle, the finished
// mask and its drop count are offered on a valid/ready channel.
module dropout_mask_gen #(
  parameter int          WIDTH        = 8,
  parameter logic [15:0] DEFAULT_SEED = dropout_pkg::DEFAULT_SEED
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               seed_load,
  input  logic [15:0]        seed_in,
  input  logic [7:0]         rate,
  dropout_mask_gen_if.master mbus,
  output logic               busy
);

  import dropout_pkg::*;

  localparam int                LANE_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(WIDTH - 1);

  state_t            state_q;
  state_t            state_d;
  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_next;
  logic [LFSR_W-1:0] seed_safe;
  logic [LANE_W-1:0] lane_q;
  logic [7:0]        rate_q;
  logic [WIDTH-1:0]  mask_q;
  logic [4:0]        count_q;
  logic              valid_q;
  logic              busy_q;
  logic              xfer;
  logic              gen_start;
  logic              lane_step;
  logic              keep;

  lfsr16_step #(
    .ZERO_SEED (DEFAULT_SEED)
  ) u_step (
    .lfsr_cur  (lfsr_q),
    .seed_raw  (seed_in),
    .lfsr_next (lfsr_next),
    .seed_safe (seed_safe)
  );

  assign xfer = valid_q & mbus.mask_ready;
  assign keep = (lfsr_next[7:0] >= rate_q);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (enable)               state_d = GEN;
      GEN:     if (lane_q == LAST_LANE)  state_d = HOLD;
      HOLD:    if (xfer)                 state_d = enable ? GEN : IDLE;
      default:                           state_d = IDLE;
    endcase
    // A seed load overrides everything, including a coincident transfer.
    if (seed_load) state_d = IDLE;
  end

  always_comb begin
    gen_start = (state_d == GEN) && (state_q != GEN);
    lane_step = (state_q == GEN) && !seed_load;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q  <= DEFAULT_SEED;
      lane_q  <= '0;
      rate_q  <= '0;
      mask_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      // Registered from the next state so both flags track state_q exactly.
      valid_q <= (state_d == HOLD);
      busy_q  <= (state_d == GEN);

      if (seed_load) begin
        lfsr_q <= seed_safe;
      end else if (lane_step) begin
        lfsr_q         <= lfsr_next;
        mask_q[lane_q] <= keep;
        count_q        <= count_q + {4'd0, ~keep};
        lane_q         <= lane_q + 1'b1;
      end

      if (gen_start) begin
        rate_q  <= rate;
        lane_q  <= '0;
        mask_q  <= '0;
        count_q <= '0;
      end
    end
  end

  assign mbus.mask_valid = valid_q;
  assign mbus.mask       = mask_q;
  assign mbus.drop_count = count_q;
  assign busy            = busy_q;

endmodule
